// File: rtl/dmem_arb_pkg.sv
// Shared types and default widths for the data-RAM arbiter.
// Ports: none (package only).
package dmem_arb_pkg;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_ADDR_W   = 10;
    localparam int DEF_MAX_WAIT = 8;

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_FORCE
    } arb_state_t;

    typedef enum logic {
        OWN_CORE,
        OWN_LDR
    } owner_t;

endpackage

// File: rtl/dmem_arb_wait_cnt.sv
// Saturating loader starvation counter.
// Ports: CLK, RESET_N, inc (loader denied), clr, hit (reaches MAX_WAIT now).
module dmem_arb_wait_cnt #(
    parameter int MAX_WAIT = 8
) (
    input  logic CLK,
    input  logic RESET_N,
    input  logic inc,
    input  logic clr,
    output logic hit
);

    localparam int W = $clog2(MAX_WAIT + 1);
    localparam logic [W-1:0] MAX_V  = W'(MAX_WAIT);
    localparam logic [W-1:0] LAST_V = W'(MAX_WAIT - 1);

    logic [W-1:0] cnt_q;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc && cnt_q != MAX_V) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Fires on the denial that brings the count to MAX_WAIT, so the
    // forced slot is the very next cycle.
    assign hit = inc && (cnt_q >= LAST_V);

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data RAM arbiter between core and loader/debug port.
// Ports: core c_*, loader l_*, boot_done, RAM side m_*.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int MAX_WAIT = DEF_MAX_WAIT,
    parameter int BOOT_EN  = 1
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic [DATA_W-1:0] c_rdata,
    output logic              c_stall,
    input  logic              l_req,
    input  logic              l_we,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [DATA_W-1:0] l_wdata,
    output logic              l_gnt,
    output logic [DATA_W-1:0] l_rdata,
    output logic              l_rvalid,
    input  logic              boot_done,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    output logic              m_wren,
    output logic              m_rden,
    input  logic [DATA_W-1:0] m_rdata
);

    localparam arb_state_t RST_ST = (BOOT_EN != 0) ? ST_BOOT : ST_RUN;

    arb_state_t state_q;
    arb_state_t state_d;
    owner_t     owner;
    logic       gnt_c;
    logic       gnt_l;
    logic       wait_inc;
    logic       wait_clr;
    logic       wait_hit;
    logic       l_rvalid_q;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= RST_ST;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        gnt_c   = 1'b0;
        gnt_l   = 1'b0;
        c_stall = 1'b0;
        state_d = state_q;
        unique case (state_q)
            ST_BOOT: begin
                gnt_l   = l_req;
                c_stall = 1'b1;
                if (boot_done) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (c_req) begin
                    gnt_c = 1'b1;
                end else begin
                    gnt_l = l_req;
                end
                if (wait_hit) begin
                    state_d = ST_FORCE;
                end
            end
            ST_FORCE: begin
                gnt_l   = l_req;
                c_stall = c_req;
                state_d = ST_RUN;
            end
            default: begin
                state_d = RST_ST;
            end
        endcase
        // No RAM traffic while reset is held, even mid-cycle.
        if (!RESET_N) begin
            gnt_c   = 1'b0;
            gnt_l   = 1'b0;
            c_stall = (BOOT_EN != 0);
        end
    end

    assign wait_inc = (state_q == ST_RUN) && c_req && l_req;
    assign wait_clr = gnt_l || !l_req || (state_q == ST_BOOT);

    dmem_arb_wait_cnt #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_cnt (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .inc     (wait_inc),
        .clr     (wait_clr),
        .hit     (wait_hit)
    );

    assign owner = gnt_l ? OWN_LDR : OWN_CORE;

    always_comb begin
        m_addr  = c_addr;
        m_wdata = c_wdata;
        m_wren  = gnt_c & c_we;
        m_rden  = gnt_c & ~c_we;
        if (owner == OWN_LDR) begin
            m_addr  = l_addr;
            m_wdata = l_wdata;
            m_wren  = l_we;
            m_rden  = ~l_we;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            l_rvalid_q <= 1'b0;
        end else begin
            l_rvalid_q <= gnt_l & ~l_we;
        end
    end

    assign l_gnt    = gnt_l;
    assign l_rvalid = l_rvalid_q;
    assign c_rdata  = m_rdata;
    assign l_rdata  = m_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 1024x32 RAM.
// Ports: none (top-level bench).
module tb_dmem_arbiter;

    logic        CLK;
    logic        rst_n;
    logic        c_req, c_we, c_stall;
    logic [9:0]  c_addr;
    logic [31:0] c_wdata, c_rdata;
    logic        l_req, l_we, l_gnt, l_rvalid;
    logic [9:0]  l_addr;
    logic [31:0] l_wdata, l_rdata;
    logic        boot_done;
    logic [9:0]  m_addr;
    logic [31:0] m_wdata, m_rdata;
    logic        m_wren, m_rden;
    logic [31:0] mem [1024];

    logic        b_rst_n;
    logic        b_c_req, b_c_we, b_c_stall;
    logic [9:0]  b_c_addr;
    logic [31:0] b_c_wdata, b_c_rdata;
    logic        b_l_gnt, b_l_rvalid;
    logic [31:0] b_l_rdata;
    logic [9:0]  b_m_addr;
    logic [31:0] b_m_wdata, b_m_rdata;
    logic        b_m_wren, b_m_rden;
    logic [31:0] b_mem [1024];

    int checks = 0;
    int errors = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always_ff @(posedge CLK) begin
        if (m_wren) mem[m_addr] <= m_wdata;
        if (m_rden) m_rdata <= mem[m_addr];
        if (b_m_wren) b_mem[b_m_addr] <= b_m_wdata;
        if (b_m_rden) b_m_rdata <= b_mem[b_m_addr];
    end

    dmem_arbiter #(.MAX_WAIT(8), .BOOT_EN(1)) dut (
        .CLK(CLK), .RESET_N(rst_n),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr),
        .c_wdata(c_wdata), .c_rdata(c_rdata), .c_stall(c_stall),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr),
        .l_wdata(l_wdata), .l_gnt(l_gnt), .l_rdata(l_rdata),
        .l_rvalid(l_rvalid), .boot_done(boot_done),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_wren(m_wren),
        .m_rden(m_rden), .m_rdata(m_rdata)
    );

    dmem_arbiter #(.MAX_WAIT(8), .BOOT_EN(0)) dut_nb (
        .CLK(CLK), .RESET_N(b_rst_n),
        .c_req(b_c_req), .c_we(b_c_we), .c_addr(b_c_addr),
        .c_wdata(b_c_wdata), .c_rdata(b_c_rdata), .c_stall(b_c_stall),
        .l_req(1'b0), .l_we(1'b0), .l_addr(10'd0),
        .l_wdata(32'd0), .l_gnt(b_l_gnt), .l_rdata(b_l_rdata),
        .l_rvalid(b_l_rvalid), .boot_done(1'b0),
        .m_addr(b_m_addr), .m_wdata(b_m_wdata), .m_wren(b_m_wren),
        .m_rden(b_m_rden), .m_rdata(b_m_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; b_rst_n = 1'b0;
        c_req = 1'b1; c_we = 1'b0; c_addr = '0; c_wdata = '0;
        l_req = 1'b1; l_we = 1'b0; l_addr = '0; l_wdata = '0;
        boot_done = 1'b0;
        b_c_req = 1'b1; b_c_we = 1'b0; b_c_addr = 10'd2; b_c_wdata = '0;
        #2;
        check("rst_wren", 32'(m_wren), 32'd0);
        check("rst_rden", 32'(m_rden), 32'd0);
        check("rst_lgnt", 32'(l_gnt), 32'd0);
        check("rst_stall", 32'(c_stall), 32'd1);
        check("rst_rvalid", 32'(l_rvalid), 32'd0);
        check("nb_rst_stall", 32'(b_c_stall), 32'd0);
        check("nb_rst_rden", 32'(b_m_rden), 32'd0);

        // BOOT preload with the core requesting throughout.
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            l_req = 1'b1; l_we = 1'b1;
            l_addr = 10'(i); l_wdata = 32'hA5A5_0000 + 32'(i);
            #1;
            check("boot_stall", 32'(c_stall), 32'd1);
            check("boot_lgnt", 32'(l_gnt), 32'd1);
            check("boot_wren", 32'(m_wren), 32'd1);
            tick();
        end
        l_req = 1'b0; l_we = 1'b0;
        boot_done = 1'b1;
        #1;
        check("boot_done_stall", 32'(c_stall), 32'd1);
        tick();
        boot_done = 1'b0;
        c_req = 1'b1; c_we = 1'b0; c_addr = 10'd5;
        #1;
        check("run_rd_stall", 32'(c_stall), 32'd0);
        check("run_rd_rden", 32'(m_rden), 32'd1);
        tick();
        check("run_rd_data", c_rdata, 32'hA5A5_0005);

        // Core priority with forced loader slot every 9th cycle.
        c_req = 1'b1; c_we = 1'b0; c_addr = 10'd0;
        l_req = 1'b1; l_we = 1'b0; l_addr = 10'd3;
        for (int k = 1; k <= 18; k++) begin
            #1;
            check($sformatf("prio_lgnt_%0d", k), 32'(l_gnt),
                  (k % 9 == 0) ? 32'd1 : 32'd0);
            check($sformatf("prio_stall_%0d", k), 32'(c_stall),
                  (k % 9 == 0) ? 32'd1 : 32'd0);
            tick();
        end

        // Core stores 0x1234 at address 3 for the idle-core read.
        l_req = 1'b0;
        c_req = 1'b1; c_we = 1'b1; c_addr = 10'd3; c_wdata = 32'h1234;
        #1;
        check("cwr_stall", 32'(c_stall), 32'd0);
        check("cwr_wren", 32'(m_wren), 32'd1);
        tick();

        c_req = 1'b0; c_we = 1'b0;
        l_req = 1'b1; l_we = 1'b0; l_addr = 10'd3;
        #1;
        check("idle_lgnt", 32'(l_gnt), 32'd1);
        check("idle_rden", 32'(m_rden), 32'd1);
        check("idle_addr", 32'(m_addr), 32'd3);
        tick();
        l_req = 1'b0;
        check("idle_rvalid", 32'(l_rvalid), 32'd1);
        check("idle_rdata", l_rdata, 32'h1234);
        tick();
        check("idle_rvalid_drop", 32'(l_rvalid), 32'd0);

        // Same-address write collision.
        c_req = 1'b1; c_we = 1'b1; c_addr = 10'd7; c_wdata = 32'h11;
        l_req = 1'b1; l_we = 1'b1; l_addr = 10'd7; l_wdata = 32'h22;
        #1;
        check("coll_lgnt", 32'(l_gnt), 32'd0);
        check("coll_stall", 32'(c_stall), 32'd0);
        tick();
        check("coll_mem", mem[7], 32'h11);
        c_req = 1'b0; c_we = 1'b0;
        #1;
        check("retry_lgnt", 32'(l_gnt), 32'd1);
        tick();
        check("retry_mem", mem[7], 32'h22);

        // Reset asserted the cycle after a loader read grant.
        c_req = 1'b1; c_we = 1'b0;
        l_req = 1'b1; l_we = 1'b0; l_addr = 10'd3;
        c_req = 1'b0;
        #1;
        check("mid_lgnt", 32'(l_gnt), 32'd1);
        tick();
        check("mid_rvalid", 32'(l_rvalid), 32'd1);
        c_req = 1'b1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_rvalid", 32'(l_rvalid), 32'd0);
        check("mid_rst_rden", 32'(m_rden), 32'd0);
        check("mid_rst_wren", 32'(m_wren), 32'd0);
        check("mid_rst_lgnt", 32'(l_gnt), 32'd0);
        check("mid_rst_stall", 32'(c_stall), 32'd1);
        tick();
        rst_n = 1'b1;
        #1;
        check("post_rst_stall", 32'(c_stall), 32'd1);
        check("post_rst_lgnt", 32'(l_gnt), 32'd1);
        tick();
        l_req = 1'b0; c_req = 1'b0;

        // BOOT_EN = 0: core served on the first cycle out of reset.
        b_rst_n = 1'b1;
        #1;
        check("nb_stall", 32'(b_c_stall), 32'd0);
        check("nb_rden", 32'(b_m_rden), 32'd1);
        check("nb_addr", 32'(b_m_addr), 32'd2);
        check("nb_lgnt", 32'(b_l_gnt), 32'd0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
